// File: rtl/seq_shifter.sv
// Multi-cycle serial shifter: shifts or rotates one bit per clock through
// SLL/SRL/SRA/ROR and reports the final word plus the last bit pushed out.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_val,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  input  logic             in_ins,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_o,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] res_q;
  logic             o_q;
  logic [AMT_W-1:0] cnt_q;
  logic [1:0]       mode_q;
  logic             ins_q;

  logic [AMT_W-1:0] amt_clamp_d;
  logic [WIDTH-1:0] step_res_d;
  logic             step_o_d;

  // One single-bit step; returns {bit shifted out, new word}.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] v,
                                                input logic [1:0] m,
                                                input logic ins);
    case (m)
      2'b00:   shift_step = {v[WIDTH-1], v[WIDTH-2:0], ins};
      2'b01:   shift_step = {v[0], ins, v[WIDTH-1:1]};
      2'b10:   shift_step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: shift_step = {v[0], v[0], v[WIDTH-1:1]};
    endcase
  endfunction

  always_comb begin
    amt_clamp_d = in_amt;
    if (in_amt > AMT_W'(WIDTH)) begin
      amt_clamp_d = AMT_W'(WIDTH);
    end else begin
      amt_clamp_d = in_amt;
    end
    {step_o_d, step_res_d} = shift_step(res_q, mode_q, ins_q);
  end

  // Control FSM and datapath registers; mode/fill are frozen at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      o_q     <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      ins_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            res_q   <= in_val;
            o_q     <= 1'b0;
            mode_q  <= in_mode;
            ins_q   <= in_ins;
            cnt_q   <= amt_clamp_d;
            state_q <= (amt_clamp_d == AMT_W'(0)) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          res_q <= step_res_d;
          o_q   <= step_o_d;
          cnt_q <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_res   = res_q;
  assign out_o     = o_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed plus randomized bench for seq_shifter (WIDTH=16) with an
// arithmetic reference model of the four shift modes.
module tb_seq_shifter;
  localparam int W  = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_val;
  logic [AW-1:0] in_amt;
  logic [1:0]    in_mode;
  logic          in_ins;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res;
  logic          out_o;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  seq_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_val(in_val), .in_amt(in_amt), .in_mode(in_mode), .in_ins(in_ins),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_o(out_o), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: n bits at once using ordinary shifts.
  task automatic model(input logic [W-1:0] v, input int amt, input logic [1:0] m,
                       input logic ins, output logic [W-1:0] r, output logic o);
    int n;
    logic [31:0] wide;
    logic [W-1:0] ones;
    int signed sv;
    n = (amt > W) ? W : amt;
    ones = '1;
    r = v;
    o = 1'b0;
    if (n > 0) begin
      o = v[n-1];
      case (m)
        2'b00: begin
          wide = {16'h0000, v} << n;
          if (ins) wide = wide | ((32'd1 << n) - 32'd1);
          r = wide[W-1:0];
          o = v[W-n];
        end
        2'b01: r = (v >> n) | (ins ? ~(ones >> n) : 16'h0000);
        2'b10: begin
          sv = $signed(v);
          sv = sv >>> n;
          r = sv[W-1:0];
        end
        default: begin
          wide = {v, v} >> n;
          r = wide[W-1:0];
        end
      endcase
    end
  endtask

  // Full transaction starting from a negedge in IDLE.
  task automatic do_op(input string tag, input logic [W-1:0] v, input logic [AW-1:0] amt,
                       input logic [1:0] m, input logic ins, input int bp,
                       input logic [W-1:0] er, input logic eo);
    int n;
    int edges;
    n = (amt > W) ? W : int'(amt);
    check({tag, "/in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_val = v; in_amt = amt; in_mode = m; in_ins = ins;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_val = ~v; in_mode = ~m; in_ins = ~ins; in_amt = AW'($urandom);
    edges = 1;
    while (!out_valid && edges < 40) begin
      in_valid = 1'($urandom);
      @(posedge clk); @(negedge clk);
      edges++;
    end
    in_valid = 1'b0;
    check({tag, "/latency"}, edges, n + 1);
    check({tag, "/res"}, out_res, er);
    check({tag, "/o"}, out_o, eo);
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      check({tag, "/bp_valid"}, out_valid, 1);
      check({tag, "/bp_res"}, out_res, er);
      check({tag, "/bp_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/drain_valid"}, out_valid, 0);
    check({tag, "/drain_busy"}, busy, 0);
  endtask

  initial begin
    logic [W-1:0] er;
    logic         eo;
    logic [W-1:0] rv;
    logic [AW-1:0] ra;
    logic [1:0]   rm;
    logic         ri;

    rst_n = 1'b0; in_valid = 1'b0; in_val = '0; in_amt = '0;
    in_mode = 2'b00; in_ins = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("rst/valid", out_valid, 0);
    check("rst/res", out_res, 0);
    check("rst/o", out_o, 0);
    check("rst/busy", busy, 0);
    check("rst/in_ready", in_ready, 1);
    rst_n = 1'b1;

    do_op("srl1", 16'hEEEE, 5'd1, 2'b01, 1'b0, 0, 16'h7777, 1'b0);
    do_op("sll3", 16'h8001, 5'd3, 2'b00, 1'b1, 0, 16'h000F, 1'b0);
    do_op("sra4", 16'h8000, 5'd4, 2'b10, 1'b0, 0, 16'hF800, 1'b0);
    do_op("ror4", 16'h1234, 5'd4, 2'b11, 1'b0, 0, 16'h4123, 1'b0);
    do_op("ror16", 16'hA5A5, 5'd16, 2'b11, 1'b0, 0, 16'hA5A5, 1'b1);
    do_op("amt0", 16'h1234, 5'd0, 2'b01, 1'b1, 0, 16'h1234, 1'b0);
    do_op("srl20", 16'h8000, 5'd20, 2'b01, 1'b0, 0, 16'h0000, 1'b1);
    do_op("bp5", 16'h00F0, 5'd2, 2'b00, 1'b0, 5, 16'h03C0, 1'b0);

    // Reset in the middle of a 10-step shift.
    in_valid = 1'b1; in_val = 16'hBEEF; in_amt = 5'd10; in_mode = 2'b01; in_ins = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    #1 rst_n = 1'b0;
    #1;
    check("midrst/valid", out_valid, 0);
    check("midrst/res", out_res, 0);
    check("midrst/o", out_o, 0);
    check("midrst/busy", busy, 0);
    check("midrst/in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("midrst/no_pulse", out_valid, 0);
    end
    do_op("after_rst", 16'hBEEF, 5'd10, 2'b01, 1'b1, 0, 16'hFFEF, 1'b1);

    for (int k = 0; k < 24; k++) begin
      rv = W'($urandom);
      ra = AW'($urandom_range(0, 31));
      rm = 2'($urandom);
      ri = 1'($urandom);
      model(rv, int'(ra), rm, ri, er, eo);
      do_op($sformatf("rnd%0d", k), rv, ra, rm, ri, $urandom_range(0, 2), er, eo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
